// File: rtl/pe_out_fifo_pkg.sv
// pe_out_fifo_pkg: shared packet field sizes and offset helpers for the PE output stage.
package pe_out_fifo_pkg;
  localparam int X_SIZE_DEF  = 2;
  localparam int Y_SIZE_DEF  = 2;
  localparam int PCK_NUM_DEF = 5;
  localparam int ITER_DEF    = 32;
  localparam int DEPTH_DEF   = 4;
  function automatic int total_w(input int x, input int y, input int p, input int i);
    return x + y + p + 8 * i;
  endfunction
  function automatic int pkt_lsb(input int x, input int y);
    return x + y;
  endfunction
endpackage

// File: rtl/sync_fwft_fifo.sv
// sync_fwft_fifo: first-word-fall-through FIFO; head entry is visible on dout whenever not empty.
module sync_fwft_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wr, rd;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  always_comb begin
    rd    = pop && cnt_q != '0;
    wr    = push && (cnt_q != CW'(DEPTH) || rd);
    wp_d  = wr ? wp_q + AW'(1) : wp_q;
    rp_d  = rd ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q + CW'(wr) - CW'(rd);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q] <= din;
  end
  assign dout  = mem_q[rp_q];
  assign full  = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
endmodule

// File: rtl/pe_out_fifo.sv
// pe_out_fifo: buffers PE result packets, stamps the return destination, flags drops and frame ends.
module pe_out_fifo
  import pe_out_fifo_pkg::*;
#(
  parameter int X_SIZE  = X_SIZE_DEF,
  parameter int Y_SIZE  = Y_SIZE_DEF,
  parameter int PCK_NUM = PCK_NUM_DEF,
  parameter int ITER    = ITER_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  localparam int TOTAL_W = total_w(X_SIZE, Y_SIZE, PCK_NUM, ITER)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [TOTAL_W-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [X_SIZE-1:0]  i_dest_x,
  input  logic [Y_SIZE-1:0]  i_dest_y,
  output logic [TOTAL_W-1:0] o_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_frame_done,
  output logic               o_overflow,
  output logic [PCK_NUM:0]   o_pkt_count
);
  localparam int PL = pkt_lsb(X_SIZE, Y_SIZE);
  localparam int CW = $clog2(DEPTH) + 1;
  logic full, empty, pop, push, drop;
  logic [CW-1:0] count;
  logic [TOTAL_W-1:0] entry;
  logic ovf_q, ovf_d, fd_q, fd_d;
  logic [PCK_NUM:0] pc_q, pc_d;
  logic unused_dest;
  // The PE zeroes its destination bits; they are replaced, so the incoming ones go unread.
  assign unused_dest = ^i_data[PL-1:0];
  sync_fwft_fifo #(.W(TOTAL_W), .DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (entry),
    .dout (o_data),
    .full (full),
    .empty(empty),
    .count(count)
  );
  always_comb begin
    pop   = !empty && i_ready;
    push  = i_valid && (!full || pop);
    drop  = i_valid && count == CW'(DEPTH) && !pop;
    entry = {i_data[TOTAL_W-1:PL], i_dest_y, i_dest_x};
    ovf_d = ovf_q || drop;
    fd_d  = pop && &o_data[PL +: PCK_NUM];
    pc_d  = pc_q + (PCK_NUM+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      fd_q  <= 1'b0;
      pc_q  <= '0;
    end else begin
      ovf_q <= ovf_d;
      fd_q  <= fd_d;
      pc_q  <= pc_d;
    end
  end
  assign o_valid      = !empty;
  assign o_ready      = !full;
  assign o_overflow   = ovf_q;
  assign o_frame_done = fd_q;
  assign o_pkt_count  = pc_q;
endmodule

// File: tb/tb_pe_out_fifo.sv
// tb_pe_out_fifo: randomized and directed checks of pe_out_fifo against a queue-based model.
module tb_pe_out_fifo;
  localparam int X = 2, Y = 2, P = 5, I = 32, D = 4, W = X + Y + P + 8 * I;
  logic clk = 0, rst = 1;
  logic [W-1:0] i_data = '0;
  logic i_valid = 0, i_ready = 0;
  logic [X-1:0] i_dest_x = '0;
  logic [Y-1:0] i_dest_y = '0;
  logic o_ready, o_valid, o_frame_done, o_overflow;
  logic [W-1:0] o_data;
  logic [P:0] o_pkt_count;
  int total = 0, bad = 0;
  logic [W-1:0] mq[$];
  logic m_ovf = 0, m_fd = 0;
  logic [P:0] m_pc = '0;
  bit m_deq, m_full;
  logic [W-1:0] m_head;

  always #5 clk = ~clk;

  pe_out_fifo dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .i_dest_x(i_dest_x), .i_dest_y(i_dest_y), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_frame_done(o_frame_done), .o_overflow(o_overflow),
    .o_pkt_count(o_pkt_count)
  );

  // Reference model: a packet queue of at most D entries.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_ovf = 0;
      m_fd = 0;
      m_pc = '0;
    end else begin
      m_full = mq.size() == D;
      m_deq = mq.size() != 0 && i_ready;
      m_fd = 0;
      if (m_deq) begin
        m_head = mq.pop_front();
        m_fd = m_head[X+Y +: P] == 5'd31;
        m_pc = m_pc + 1'b1;
      end
      if (i_valid) begin
        if (!m_full || m_deq) mq.push_back({i_data[W-1:X+Y], i_dest_y, i_dest_x});
        else m_ovf = 1;
      end
    end
  end

  function automatic logic [P+4:0] exp_st();
    return {mq.size() != 0, mq.size() != D, m_ovf, m_fd, m_pc};
  endfunction

  function automatic logic [W-1:0] rand_pkt(input logic [P-1:0] pkt);
    logic [W-1:0] d;
    for (int k = 0; k < 8; k++) d[9 + 32*k +: 32] = $urandom;
    d[8:0] = {pkt, 4'($urandom)};
    return d;
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] d, input logic rdy,
                       input logic [X-1:0] dx, input logic [Y-1:0] dy);
    i_valid = v;
    i_data = d;
    i_ready = rdy;
    i_dest_x = dx;
    i_dest_y = dy;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1;
    drive(0, '0, 0, 0, 0);
    tick();
    tick();
    total++;
    if ({o_valid, o_ready, o_overflow, o_frame_done, o_pkt_count} !== {4'b0100, 6'd0}) begin
      bad++;
      $display("FAIL reset_state got=%b exp=%b", {o_valid, o_ready, o_overflow, o_frame_done, o_pkt_count}, {4'b0100, 6'd0});
    end
    rst = 0;
    tick();
    total++;
    if ({o_valid, o_ready} !== 2'b01) begin
      bad++;
      $display("FAIL reset_idle got=%b exp=01", {o_valid, o_ready});
    end
  endtask

  task automatic test_single();
    logic [W-1:0] d;
    logic [255:0] pay;
    for (int k = 0; k < 32; k++) pay[8*k +: 8] = 8'(k);
    d = {pay, 5'd3, 4'b0000};
    drive(1, d, 1, 2'd1, 2'd2);
    tick();
    drive(0, '0, 1, 0, 0);
    total++;
    if (o_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", o_valid); end
    total++;
    if (o_data[3:0] !== 4'b1001) begin bad++; $display("FAIL single_dest got=%b exp=1001", o_data[3:0]); end
    total++;
    if (o_data[8:4] !== 5'd3) begin bad++; $display("FAIL single_pkt got=%0d exp=3", o_data[8:4]); end
    total++;
    if (o_data[W-1:9] !== pay) begin bad++; $display("FAIL single_payload got=%h exp=%h", o_data[W-1:9], pay); end
    tick();
    total++;
    if ({o_valid, o_pkt_count} !== {1'b0, 6'd1}) begin
      bad++;
      $display("FAIL single_count got=%b/%0d exp=0/1", o_valid, o_pkt_count);
    end
  endtask

  task automatic test_fill();
    logic [P-1:0] exp_pkt;
    for (int k = 0; k < 4; k++) begin
      drive(1, rand_pkt(5'(k)), 0, 2'($urandom), 2'($urandom));
      tick();
      total++;
      if (o_ready !== (k < 3)) begin bad++; $display("FAIL fill_ready%0d got=%b exp=%b", k, o_ready, k < 3); end
    end
    drive(1, rand_pkt(5'd9), 0, 2'($urandom), 2'($urandom));
    tick();
    drive(0, '0, 0, 0, 0);
    tick();
    total++;
    if ({o_overflow, o_ready, o_valid, o_data[8:4]} !== {3'b101, 5'd0}) begin
      bad++;
      $display("FAIL overflow got=%b exp=10100000", {o_overflow, o_ready, o_valid, o_data[8:4]});
    end
    total++;
    if (o_data !== mq[0]) begin bad++; $display("FAIL overflow_head got=%h exp=%h", o_data, mq[0]); end
    drive(1, rand_pkt(5'd4), 1, 2'($urandom), 2'($urandom));
    tick();
    total++;
    if ({o_ready, o_overflow, o_data[8:4]} !== {2'b01, 5'd1}) begin
      bad++;
      $display("FAIL full_pushpop got=%b exp=0100001", {o_ready, o_overflow, o_data[8:4]});
    end
    drive(0, '0, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      exp_pkt = 5'(k + 1);
      total++;
      if ({o_valid, o_data[8:4]} !== {1'b1, exp_pkt}) begin
        bad++;
        $display("FAIL drain%0d got=%b/%0d exp=1/%0d", k, o_valid, o_data[8:4], exp_pkt);
      end
      total++;
      if (o_data !== mq[0]) begin bad++; $display("FAIL drain_data%0d got=%h exp=%h", k, o_data, mq[0]); end
      tick();
    end
    total++;
    if ({o_valid, o_ready, o_overflow} !== 3'b011) begin
      bad++;
      $display("FAIL drained got=%b exp=011", {o_valid, o_ready, o_overflow});
    end
  endtask

  task automatic test_frame();
    int pulses = 0;
    rst = 1;
    drive(0, '0, 1, 0, 0);
    tick();
    rst = 0;
    total++;
    if (o_overflow !== 1'b0) begin bad++; $display("FAIL overflow_clear got=%b exp=0", o_overflow); end
    for (int k = 0; k < 35; k++) begin
      if (k < 32) drive(1, rand_pkt(5'(k)), 1, 2'($urandom), 2'($urandom));
      else drive(0, '0, 1, 0, 0);
      tick();
      pulses += int'(o_frame_done);
      total++;
      if ({o_valid, o_ready, o_overflow, o_frame_done, o_pkt_count} !== exp_st()) begin
        bad++;
        $display("FAIL frame_st%0d got=%b exp=%b", k, {o_valid, o_ready, o_overflow, o_frame_done, o_pkt_count}, exp_st());
      end
    end
    total++;
    if (pulses != 1 || o_pkt_count !== 6'd32) begin
      bad++;
      $display("FAIL frame_done got=%0d/%0d exp=1/32", pulses, o_pkt_count);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      drive(1'($urandom_range(0, 9) < 7), rand_pkt(5'($urandom)), 1'($urandom_range(0, 9) < 5),
            2'($urandom), 2'($urandom));
      tick();
      total++;
      if ({o_valid, o_ready, o_overflow, o_frame_done, o_pkt_count} !== exp_st()) begin
        bad++;
        $display("FAIL rand_st%0d got=%b exp=%b", k, {o_valid, o_ready, o_overflow, o_frame_done, o_pkt_count}, exp_st());
      end
      if (mq.size() != 0) begin
        total++;
        if (o_data !== mq[0]) begin bad++; $display("FAIL rand_data%0d got=%h exp=%h", k, o_data, mq[0]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] d;
    rst = 1;
    drive(0, '0, 0, 0, 0);
    tick();
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      drive(1, rand_pkt(5'(k)), 0, 2'($urandom), 2'($urandom));
      tick();
    end
    drive(0, '0, 0, 0, 0);
    total++;
    if ({o_valid, o_ready} !== 2'b11) begin bad++; $display("FAIL mid_buffered got=%b exp=11", {o_valid, o_ready}); end
    rst = 1;
    tick();
    rst = 0;
    total++;
    if ({o_valid, o_ready, o_overflow, o_frame_done, o_pkt_count} !== {4'b0100, 6'd0}) begin
      bad++;
      $display("FAIL mid_reset got=%b exp=%b", {o_valid, o_ready, o_overflow, o_frame_done, o_pkt_count}, {4'b0100, 6'd0});
    end
    d = rand_pkt(5'd7);
    drive(1, d, 0, 2'd3, 2'd0);
    tick();
    drive(0, '0, 0, 0, 0);
    total++;
    if ({o_valid, o_data} !== {1'b1, d[W-1:4], 4'b0011}) begin
      bad++;
      $display("FAIL mid_push got=%b/%h exp=1/%h", o_valid, o_data, {d[W-1:4], 4'b0011});
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_frame();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
